calc_input_sequencer: RTL and testbench
=======================================

// Module: calc_input_sequencer
// PURPOSE
//  Operator-side front end of the 4-bit calculator. It debounces the ENTER and CLEAR keys, then
//  steps the operator through entering operand A, operand B and the opcode from sw[3:0]. It drives
//  registered operands and opcode into the combinational ALU, then latches the ALU's 8-bit result
//  and flags[3:0] for the display. The flags are ordered [carry, negative, overflow, zero].
//  It sits between the board I/O (switches, keys) and alu / display logic.
// PARAMETERS
//  DEBOUNCE_CYCLES  50000  stable-level cycles required before a key change is accepted (>=2)
//  CNT_W            16     width of debounce counter; must hold DEBOUNCE_CYCLES-1
// PORTS
//  clk           in   1  system clock; single clock domain
//  rst_n         in   1  asynchronous, active-low reset
//  sw            in   4  operand/opcode switches, asynchronous
//  key_enter_n   in   1  raw ENTER key, active-low, bouncing, asynchronous
//  key_clear_n   in   1  raw CLEAR key, active-low, bouncing, asynchronous
//  alu_a         out  4  operand A register to ALU
//  alu_b         out  4  operand B register to ALU
//  alu_op        out  4  opcode register to ALU
//  alu_result    in   8  ALU combinational result
//  alu_flags     in   4  ALU combinational flags
//  result_q      out  8  latched result for display
//  flags_q       out  4  latched flags for display
//  result_valid  out  1  high while result_q/flags_q hold a completed operation
//  op_err        out  1  last opcode entry was not a legal opcode
//  state_o       out  3  current FSM state (for LEDs/debug)
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0; state GET_A; debounce counters 0; stable key levels 1.
//  Input sync: sw, key_enter_n and key_clear_n each pass through a 2-FF synchronizer.
//  Debounce, per key:
//   - While the synced level differs from the stable level, the counter increments.
//   - While they are equal, the counter clears.
//   - When the counter reaches DEBOUNCE_CYCLES-1, the stable level takes the synced level.
//   - A stable 1->0 transition produces a one-cycle pulse, enter_p or clr_p.
//   - Latency from a clean key edge to the pulse is 2+DEBOUNCE_CYCLES cycles.
//   - Any glitch shorter than DEBOUNCE_CYCLES produces no pulse.
//  FSM states and encoding: GET_A=0, GET_B=1, GET_OP=2, EXEC=3, SHOW=4.
//   - GET_A, on enter_p: a_q<=sw_s, state->GET_B.
//   - GET_B, on enter_p: b_q<=sw_s, state->GET_OP.
//   - GET_OP, on enter_p, legal opcode: op_q<=sw_s, op_err<=0, state->EXEC.
//     Legal opcodes are 4'b0110..4'b1111.
//   - GET_OP, on enter_p, illegal opcode (0000..0101): op_q is unchanged, op_err<=1, state stays GET_OP.
//   - EXEC lasts exactly 1 cycle and enter_p is ignored. At its closing edge:
//     result_q<=alu_result, flags_q<=alu_flags, result_valid<=1, state->SHOW.
//   - SHOW holds result_q, flags_q and result_valid. On enter_p: result_valid<=0,
//     a_q<=0, b_q<=0, op_q<=0, state->GET_A. result_q/flags_q keep their last values.
//  Clear:
//   - clr_p in any state: a_q, b_q, op_q, result_q and flags_q <=0; result_valid<=0; op_err<=0;
//     state->GET_A.
//   - clr_p takes priority over a simultaneous enter_p.
//  ALU interface: alu_a=a_q, alu_b=b_q, alu_op=op_q, all driven straight from registers.
//   - They are stable for the whole EXEC cycle.
//   - The ALU is purely combinational, so one cycle is sufficient.
//   - Operand capture latency: the value is visible on alu_a/alu_b/alu_op one cycle after enter_p.
//   - result_valid rises 2 edges after the enter_p cycle that accepts the opcode.
//  Unreachable state encodings (5..7) return to GET_A on the next edge with registers unchanged.
//  Reset asserted mid-operation aborts immediately; there is no partial result.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//  1. Enter A=3, B=5, op=4'b1111 (clean presses) -> alu_a=3, alu_b=5, result_q=8'h08,
//     flags_q=4'b0000, result_valid=1, state_o=4.
//  2. Enter A=F, B=1, op=4'b1111 -> result_q=8'h00, flags_q=4'b1001 (carry+zero).
//  3. In GET_OP, press with sw=4'b0011 -> op_err=1, state_o=2, no result_valid.
//     Then press with sw=4'b1010 -> op_err=0, state reaches SHOW.
//  4. Bounce ENTER low for 2 cycles, three times -> no capture, state_o stays 0.
//     Then hold low for 10 cycles -> exactly one capture.
//  5. In GET_B, press ENTER and CLEAR with identical timing -> state_o=0,
//     a_q=b_q=op_q=0, result_valid=0.
//  6. Assert rst_n=0 mid-SHOW (async, between edges) -> all outputs 0 immediately, state_o=0.

Source files
------------

// File: rtl/calc_input_sequencer_if.sv
// ALU-side bus of the calculator input sequencer: registered operands/opcode out,
// combinational result and flags back.
interface calc_input_sequencer_if;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_op;
    logic [7:0] alu_result;
    logic [3:0] alu_flags;   // [carry, negative, overflow, zero]

    modport master (
        output alu_a,
        output alu_b,
        output alu_op,
        input  alu_result,
        input  alu_flags
    );

    modport slave (
        input  alu_a,
        input  alu_b,
        input  alu_op,
        output alu_result,
        output alu_flags
    );
endinterface

// File: rtl/calc_input_sequencer.sv
// Operator front end of the 4-bit calculator: key debounce, A/B/opcode entry FSM,
// and latching of the ALU result and flags for the display.
module calc_input_sequencer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [3:0]             sw,
    input  logic                   key_enter_n,
    input  logic                   key_clear_n,
    calc_input_sequencer_if.master alu,
    output logic [7:0]             result_q,
    output logic [3:0]             flags_q,
    output logic                   result_valid,
    output logic                   op_err,
    output logic [2:0]             state_o
);

    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        GET_OP = 3'd2,
        EXEC   = 3'd3,
        SHOW   = 3'd4
    } state_t;

    localparam int KEY_ENTER = 0;
    localparam int KEY_CLEAR = 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] OP_FIRST_LEGAL = 4'b0110;

    logic [3:0]       sw_meta;
    logic [3:0]       sw_s;
    logic [1:0]       key_meta;
    logic [1:0]       key_sync;
    logic [1:0]       key_stable;
    logic [1:0]       key_fall;
    logic [CNT_W-1:0] deb_cnt [2];

    state_t     state;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [3:0] op_q;

    logic enter_p;
    logic clr_p;

    assign enter_p = key_fall[KEY_ENTER];
    assign clr_p   = key_fall[KEY_CLEAR];

    // Two-flop synchronizers; keys idle high so they reset to 1 to avoid a fake press.
    // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta  <= '0;
            sw_s     <= '0;
            key_meta <= 2'b11;
            key_sync <= 2'b11;
        end else begin
            sw_meta  <= sw;
            sw_s     <= sw_meta;
            key_meta <= {key_clear_n, key_enter_n};
            key_sync <= key_meta;
        end
    end

    // Per-key debounce: the level must differ from the stable value for DEBOUNCE_CYCLES
    // consecutive cycles before it is accepted; a 1->0 acceptance emits a one-cycle pulse.
    // NOTE: the two-entry counter array is a register file of flops, so it is reset like any
    // other state; a large RAM-style memory would normally be left out of the reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_stable <= 2'b11;
            key_fall   <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                deb_cnt[k] <= '0;
            end
        end else begin
            key_fall <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                if (key_sync[k] != key_stable[k]) begin
                    if (deb_cnt[k] == CNT_LAST) begin
                        key_stable[k] <= key_sync[k];
                        key_fall[k]   <= key_stable[k];
                        deb_cnt[k]    <= '0;
                    end else begin
                        deb_cnt[k] <= deb_cnt[k] + 1'b1;
                    end
                end else begin
                    deb_cnt[k] <= '0;
                end
            end
        end
    end

    // Entry sequencer; CLEAR outranks ENTER in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= GET_A;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            result_q     <= '0;
            flags_q      <= '0;
            result_valid <= 1'b0;
            op_err       <= 1'b0;
        end else if (clr_p) begin
            state        <= GET_A;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            result_q     <= '0;
            flags_q      <= '0;
            result_valid <= 1'b0;
            op_err       <= 1'b0;
        end else begin
            case (state)
                GET_A: begin
                    if (enter_p) begin
                        a_q   <= sw_s;
                        state <= GET_B;
                    end
                end
                GET_B: begin
                    if (enter_p) begin
                        b_q   <= sw_s;
                        state <= GET_OP;
                    end
                end
                GET_OP: begin
                    if (enter_p) begin
                        if (sw_s >= OP_FIRST_LEGAL) begin
                            op_q   <= sw_s;
                            op_err <= 1'b0;
                            state  <= EXEC;
                        end else begin
                            op_err <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    // Operands have been stable on the ALU for this whole cycle.
                    result_q     <= alu.alu_result;
                    flags_q      <= alu.alu_flags;
                    result_valid <= 1'b1;
                    state        <= SHOW;
                end
                SHOW: begin
                    if (enter_p) begin
                        result_valid <= 1'b0;
                        a_q          <= '0;
                        b_q          <= '0;
                        op_q         <= '0;
                        state        <= GET_A;
                    end
                end
                default: state <= GET_A;
            endcase
        end
    end

    assign alu.alu_a  = a_q;
    assign alu.alu_b  = b_q;
    assign alu.alu_op = op_q;
    assign state_o    = state;

endmodule

// File: tb/tb_calc_input_sequencer.sv
// Self-checking bench for calc_input_sequencer with a behavioural ALU and a result scoreboard.
module tb_calc_input_sequencer;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw = 4'h0;
    logic       key_enter_n = 1'b1;
    logic       key_clear_n = 1'b1;
    logic [7:0] result_q;
    logic [3:0] flags_q;
    logic       result_valid;
    logic       op_err;
    logic [2:0] state_o;

    calc_input_sequencer_if alu_if ();

    calc_input_sequencer #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw           (sw),
        .key_enter_n  (key_enter_n),
        .key_clear_n  (key_clear_n),
        .alu          (alu_if),
        .result_q     (result_q),
        .flags_q      (flags_q),
        .result_valid (result_valid),
        .op_err       (op_err),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: flags are {carry, negative, overflow, zero}.
    function automatic logic [11:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] op);
        logic [4:0] sum;
        logic [7:0] r;
        logic       c;
        c = 1'b0;
        case (op)
            4'b1111: begin sum = {1'b0, a} + {1'b0, b}; r = {4'h0, sum[3:0]}; c = sum[4]; end
            4'b1010: begin r = {4'h0, a} - {4'h0, b}; c = (a < b); end
            default: r = {4'h0, a ^ b};
        endcase
        return {r, c, r[7], 1'b0, (r == 8'h00)};
    endfunction

    always_comb {alu_if.alu_result, alu_if.alu_flags} = alu_fn(alu_if.alu_a, alu_if.alu_b, alu_if.alu_op);

    int          n_cmp = 0;
    int          n_err = 0;
    logic [11:0] sb_q[$];
    logic        prev_rv = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboard: each rising result_valid must match the oldest pushed expectation.
    always @(negedge clk) begin
        if (rst_n && result_valid && !prev_rv) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_result", 32'd1, 32'd0);
            end else begin
                logic [11:0] e;
                e = sb_q.pop_front();
                check("sb_result", {24'h0, result_q}, {24'h0, e[11:4]});
                check("sb_flags", {28'h0, flags_q}, {28'h0, e[3:0]});
            end
        end
        prev_rv <= rst_n & result_valid;
    end

    task automatic press(input logic [3:0] v, input bit en, input bit clr);
        @(negedge clk);
        sw = v;
        repeat (3) @(negedge clk);
        key_enter_n = ~en;
        key_clear_n = ~clr;
        repeat (10) @(negedge clk);
        key_enter_n = 1'b1;
        key_clear_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        press(a, 1'b1, 1'b0);
        check("cap_a", {28'h0, alu_if.alu_a}, {28'h0, a});
        press(b, 1'b1, 1'b0);
        check("cap_b", {28'h0, alu_if.alu_b}, {28'h0, b});
        check("state_get_op", {29'h0, state_o}, 32'd2);
        sb_q.push_back(alu_fn(a, b, op));
        press(op, 1'b1, 1'b0);
        check("state_show", {29'h0, state_o}, 32'd4);
        check("cap_op", {28'h0, alu_if.alu_op}, {28'h0, op});
        check("valid_show", {31'h0, result_valid}, 32'd1);
    endtask

    task automatic leave_show(input logic [7:0] exp_res);
        press(4'h0, 1'b1, 1'b0);
        check("exit_state", {29'h0, state_o}, 32'd0);
        check("exit_valid", {31'h0, result_valid}, 32'd0);
        check("exit_regs", {20'h0, alu_if.alu_a, alu_if.alu_b, alu_if.alu_op}, 32'd0);
        check("exit_keep_result", {24'h0, result_q}, {24'h0, exp_res});
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {7'h0, alu_if.alu_a, alu_if.alu_b, alu_if.alu_op, result_q, flags_q,
                    result_valid, op_err, state_o}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1: 3 + 5
        run_op(4'h3, 4'h5, 4'b1111);
        check("t1_result", {24'h0, result_q}, 32'h08);
        check("t1_flags", {28'h0, flags_q}, 32'b0000);
        leave_show(8'h08);

        // 2: F + 1 wraps with carry and zero
        run_op(4'hF, 4'h1, 4'b1111);
        check("t2_result", {24'h0, result_q}, 32'h00);
        check("t2_flags", {28'h0, flags_q}, 32'b1001);
        leave_show(8'h00);

        // 3: illegal opcode then legal
        press(4'h9, 1'b1, 1'b0);
        press(4'h4, 1'b1, 1'b0);
        press(4'b0011, 1'b1, 1'b0);
        check("t3_op_err_set", {31'h0, op_err}, 32'd1);
        check("t3_state_stays", {29'h0, state_o}, 32'd2);
        check("t3_no_valid", {31'h0, result_valid}, 32'd0);
        check("t3_op_unchanged", {28'h0, alu_if.alu_op}, 32'd0);
        sb_q.push_back(alu_fn(4'h9, 4'h4, 4'b1010));
        press(4'b1010, 1'b1, 1'b0);
        check("t3_op_err_clr", {31'h0, op_err}, 32'd0);
        check("t3_state_show", {29'h0, state_o}, 32'd4);
        check("t3_valid", {31'h0, result_valid}, 32'd1);
        leave_show(8'h05);

        // 4: short bounces rejected, long hold accepted once
        @(negedge clk);
        sw = 4'h7;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            key_enter_n = 1'b0;
            repeat (2) @(negedge clk);
            key_enter_n = 1'b1;
            repeat (DEB + 2) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check("t4_bounce_state", {29'h0, state_o}, 32'd0);
        check("t4_bounce_a", {28'h0, alu_if.alu_a}, 32'd0);
        key_enter_n = 1'b0;
        repeat (10) @(negedge clk);
        key_enter_n = 1'b1;
        repeat (15) @(negedge clk);
        check("t4_hold_state", {29'h0, state_o}, 32'd1);
        check("t4_hold_a", {28'h0, alu_if.alu_a}, 32'd7);

        // 5: simultaneous ENTER and CLEAR in GET_B
        press(4'h2, 1'b1, 1'b1);
        check("t5_state", {29'h0, state_o}, 32'd0);
        check("t5_regs", {20'h0, alu_if.alu_a, alu_if.alu_b, alu_if.alu_op}, 32'd0);
        check("t5_valid", {31'h0, result_valid}, 32'd0);

        // 6: async reset in SHOW
        run_op(4'h1, 4'h2, 4'b1111);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("t6_async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_state_after", {29'h0, state_o}, 32'd0);

        check("sb_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
